// File: rtl/vga_tp_pkg.sv
// Shared constants for the VGA test-pattern engine: command fields, opcodes,
// pattern indices and the colour-bar table.
package vga_tp_pkg;

    localparam int CMD_OP_MSB   = 7;
    localparam int CMD_OP_LSB   = 4;
    localparam int CMD_DATA_MSB = 3;
    localparam int CMD_DATA_LSB = 0;

    localparam logic [3:0] OP_PATTERN = 4'd0;
    localparam logic [3:0] OP_RED     = 4'd1;
    localparam logic [3:0] OP_GREEN   = 4'd2;
    localparam logic [3:0] OP_BLUE    = 4'd3;

    localparam logic [3:0] PAT_BLACK   = 4'd0;
    localparam logic [3:0] PAT_SOLID   = 4'd1;
    localparam logic [3:0] PAT_BARS    = 4'd2;
    localparam logic [3:0] PAT_CHECKER = 4'd3;
    localparam logic [3:0] PAT_BORDER  = 4'd4;
    localparam logic [3:0] PAT_RAMP    = 4'd5;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } bar_rgb_t;

    // Entry 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam bar_rgb_t [7:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/vga_tp_timing.sv
// Pixel/line counters for the VGA test-pattern engine plus the raw
// (unregistered) active-low sync decode and the last-pixel-of-frame flag.
module vga_tp_timing
    import vga_tp_pkg::*;
#(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] col_o,
    output logic [9:0] row_o,
    output logic       hsync_raw_o,
    output logic       vsync_raw_o,
    output logic       last_pixel_o
);

    localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] HS_START = 10'(ACTIVE_COLS + H_FP);
    localparam logic [9:0] HS_END   = 10'(ACTIVE_COLS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(ACTIVE_ROWS + V_FP);
    localparam logic [9:0] VS_END   = 10'(ACTIVE_ROWS + V_FP + V_SYNC);

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;

    always_comb begin
        col_d = col_q + 10'd1;
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o        = col_q;
    assign row_o        = row_q;
    assign hsync_raw_o  = !((col_q >= HS_START) && (col_q < HS_END));
    assign vsync_raw_o  = !((row_q >= VS_START) && (row_q < VS_END));
    assign last_pixel_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/vga_tp_engine.sv
// VGA test-pattern engine: command staging/shadow registers, pattern generation
// and a one-cycle registered output stage. Define VGA_TP_SCROLL_EN to make the
// colour bars scroll one pixel per frame.
module vga_tp_engine
    import vga_tp_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Cmd_DV,
    input  logic [7:0]             i_Cmd_Byte,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic [9:0]             o_Col,
    output logic [9:0]             o_Row,
    output logic                   o_Frame_Start,
    output logic [3:0]             o_Pattern
);

    localparam int                   BAR_W    = ACTIVE_COLS / 8;
    localparam logic [VIDEO_WIDTH-1:0] FULL   = '1;
    localparam logic [9:0]           COL_ACT  = 10'(ACTIVE_COLS);
    localparam logic [9:0]           ROW_ACT  = 10'(ACTIVE_ROWS);
    localparam logic [9:0]           COL_EDGE = 10'(ACTIVE_COLS - 1);
    localparam logic [9:0]           ROW_EDGE = 10'(ACTIVE_ROWS - 1);

    logic [9:0] col, row;
    logic       hs_raw, vs_raw, last_pix;

    vga_tp_timing #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS),
        .ACTIVE_COLS(ACTIVE_COLS),
        .ACTIVE_ROWS(ACTIVE_ROWS),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC)
    ) u_timing (
        .clk_i       (i_Clk),
        .rst_i       (i_Rst),
        .col_o       (col),
        .row_o       (row),
        .hsync_raw_o (hs_raw),
        .vsync_raw_o (vs_raw),
        .last_pixel_o(last_pix)
    );

    // i_Cmd_DV is a single-cycle strobe with no backpressure: the byte is
    // consumed on that cycle unless reset is high, in which case it is dropped.
    logic [3:0]             cmd_op, cmd_data;
    logic [VIDEO_WIDTH-1:0] cmd_level;

    assign cmd_op    = i_Cmd_Byte[CMD_OP_MSB:CMD_OP_LSB];
    assign cmd_data  = i_Cmd_Byte[CMD_DATA_MSB:CMD_DATA_LSB];
    assign cmd_level = cmd_data[3 -: VIDEO_WIDTH];

    logic [3:0]             pat_stg_q, pat_stg_d, pat_sh_q;
    logic [VIDEO_WIDTH-1:0] red_stg_q, red_stg_d, red_sh_q;
    logic [VIDEO_WIDTH-1:0] grn_stg_q, grn_stg_d, grn_sh_q;
    logic [VIDEO_WIDTH-1:0] blu_stg_q, blu_stg_d, blu_sh_q;

    always_comb begin
        pat_stg_d = pat_stg_q;
        red_stg_d = red_stg_q;
        grn_stg_d = grn_stg_q;
        blu_stg_d = blu_stg_q;
        if (i_Cmd_DV) begin
            case (cmd_op)
                OP_PATTERN: pat_stg_d = cmd_data;
                OP_RED:     red_stg_d = cmd_level;
                OP_GREEN:   grn_stg_d = cmd_level;
                OP_BLUE:    blu_stg_d = cmd_level;
                default:    ;
            endcase
        end
    end

    // The shadow copy reads the old staging value, so a command landing on the
    // copy cycle only reaches the screen one frame later.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            pat_stg_q <= '0;
            red_stg_q <= FULL;
            grn_stg_q <= FULL;
            blu_stg_q <= FULL;
            pat_sh_q  <= '0;
            red_sh_q  <= FULL;
            grn_sh_q  <= FULL;
            blu_sh_q  <= FULL;
        end else begin
            pat_stg_q <= pat_stg_d;
            red_stg_q <= red_stg_d;
            grn_stg_q <= grn_stg_d;
            blu_stg_q <= blu_stg_d;
            if (last_pix) begin
                pat_sh_q <= pat_stg_q;
                red_sh_q <= red_stg_q;
                grn_sh_q <= grn_stg_q;
                blu_sh_q <= blu_stg_q;
            end
        end
    end

    logic [9:0] bar_pos;

`ifdef VGA_TP_SCROLL_EN
    logic [9:0]  frame_cnt_q;
    logic [10:0] scroll_sum;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            frame_cnt_q <= '0;
        end else if (last_pix) begin
            frame_cnt_q <= frame_cnt_q + 10'd1;
        end
    end

    assign scroll_sum = {1'b0, col} + {1'b0, frame_cnt_q};
    assign bar_pos    = 10'(scroll_sum % 11'(ACTIVE_COLS));
`else
    assign bar_pos = col;
`endif

    logic [2:0] bar_idx;
    bar_rgb_t   bar_rgb;

    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            if (bar_pos >= 10'(i * BAR_W)) bar_idx = 3'(i);
        end
    end

    assign bar_rgb = BAR_TABLE[bar_idx];

    logic                   active;
    logic [VIDEO_WIDTH-1:0] red_d, grn_d, blu_d;

    assign active = (col < COL_ACT) && (row < ROW_ACT);

    always_comb begin
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        case (pat_sh_q)
            PAT_SOLID: begin
                red_d = red_sh_q;
                grn_d = grn_sh_q;
                blu_d = blu_sh_q;
            end
            PAT_BARS: begin
                red_d = {VIDEO_WIDTH{bar_rgb.r}};
                grn_d = {VIDEO_WIDTH{bar_rgb.g}};
                blu_d = {VIDEO_WIDTH{bar_rgb.b}};
            end
            PAT_CHECKER: begin
                if (col[5] ^ row[5]) begin
                    red_d = FULL;
                    grn_d = FULL;
                    blu_d = FULL;
                end
            end
            PAT_BORDER: begin
                if ((col == '0) || (col == COL_EDGE) || (row == '0) || (row == ROW_EDGE)) begin
                    red_d = FULL;
                    grn_d = FULL;
                    blu_d = FULL;
                end
            end
            PAT_RAMP: begin
                red_d = col[9 -: VIDEO_WIDTH];
                grn_d = col[9 -: VIDEO_WIDTH];
                blu_d = col[9 -: VIDEO_WIDTH];
            end
            default: ;
        endcase
        if (!active) begin
            red_d = '0;
            grn_d = '0;
            blu_d = '0;
        end
    end

    logic                   hsync_q, vsync_q, frame_start_q, frame_start_d;
    logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
    logic [9:0]             col_q, row_q;
    logic [3:0]             pat_q;

    assign frame_start_d = (col == '0) && (row == '0);

    // Every output is registered here so they all share one cycle of latency.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            red_q         <= '0;
            grn_q         <= '0;
            blu_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            frame_start_q <= 1'b0;
            pat_q         <= '0;
        end else begin
            hsync_q       <= hs_raw;
            vsync_q       <= vs_raw;
            red_q         <= red_d;
            grn_q         <= grn_d;
            blu_q         <= blu_d;
            col_q         <= col;
            row_q         <= row;
            frame_start_q <= frame_start_d;
            pat_q         <= pat_sh_q;
        end
    end

    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_Red_Video   = red_q;
    assign o_Grn_Video   = grn_q;
    assign o_Blu_Video   = blu_q;
    assign o_Col         = col_q;
    assign o_Row         = row_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Pattern     = pat_q;

endmodule

// File: tb/tb_vga_tp_engine.sv
// Scoreboard bench for vga_tp_engine on a reduced frame geometry: a pixel-index
// reference model pushes the expected output of every clock, a monitor pops and compares.
module tb_vga_tp_engine;

    localparam int VW    = 3;
    localparam int TC    = 144;
    localparam int TR    = 38;
    localparam int AC    = 136;
    localparam int AR    = 34;
    localparam int HFP   = 2;
    localparam int HSW   = 4;
    localparam int VFP   = 1;
    localparam int VSW   = 2;
    localparam int FRAME = TC * TR;
    localparam int FULL  = (1 << VW) - 1;
    localparam int W     = 4 + 1 + 10 + 10 + 1 + 1 + 3 * VW;

    logic          clk;
    logic          rst;
    logic          cmd_dv;
    logic [7:0]    cmd_byte;
    logic          hsync, vsync, frame_start;
    logic [VW-1:0] red, grn, blu;
    logic [9:0]    col, row;
    logic [3:0]    pattern;

    vga_tp_engine #(
        .VIDEO_WIDTH(VW),
        .TOTAL_COLS (TC),
        .TOTAL_ROWS (TR),
        .ACTIVE_COLS(AC),
        .ACTIVE_ROWS(AR),
        .H_FP       (HFP),
        .H_SYNC     (HSW),
        .V_FP       (VFP),
        .V_SYNC     (VSW)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Cmd_DV     (cmd_dv),
        .i_Cmd_Byte   (cmd_byte),
        .o_HSync      (hsync),
        .o_VSync      (vsync),
        .o_Red_Video  (red),
        .o_Grn_Video  (grn),
        .o_Blu_Video  (blu),
        .o_Col        (col),
        .o_Row        (row),
        .o_Frame_Start(frame_start),
        .o_Pattern    (pattern)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: pixel index of the counters, staged and shadow config
    int m_p, m_fc;
    int stg_pat, stg_r, stg_g, stg_b;
    int sh_pat, sh_r, sh_g, sh_b;
    int bar_mask[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

    function automatic logic [W-1:0] model_out(input int p, input int pat, input int r,
                                               input int g, input int b, input int fc);
        int c, rw, pos, m, vr, vg, vb;
        bit hs, vs, fs;
        c  = p % TC;
        rw = p / TC;
        fs = (p == 0);
        hs = !(c >= AC + HFP && c < AC + HFP + HSW);
        vs = !(rw >= AR + VFP && rw < AR + VFP + VSW);
        vr = 0; vg = 0; vb = 0;
        if (c < AC && rw < AR) begin
            case (pat)
                1: begin vr = r; vg = g; vb = b; end
                2: begin
`ifdef VGA_TP_SCROLL_EN
                    pos = (c + fc) % AC;
`else
                    pos = c + 0 * fc;
`endif
                    m  = bar_mask[pos / (AC / 8)];
                    vr = (m & 4) != 0 ? FULL : 0;
                    vg = (m & 2) != 0 ? FULL : 0;
                    vb = (m & 1) != 0 ? FULL : 0;
                end
                3: if (((c / 32) % 2) != ((rw / 32) % 2)) begin vr = FULL; vg = FULL; vb = FULL; end
                4: if (c == 0 || c == AC - 1 || rw == 0 || rw == AR - 1) begin
                    vr = FULL; vg = FULL; vb = FULL;
                end
                5: begin vr = c >> (10 - VW); vg = vr; vb = vr; end
                default: ;
            endcase
        end
        return {4'(pat), fs, 10'(rw), 10'(c), hs, vs, VW'(vr), VW'(vg), VW'(vb)};
    endfunction

    task automatic model_reset();
        m_p = 0; m_fc = 0;
        stg_pat = 0; stg_r = FULL; stg_g = FULL; stg_b = FULL;
        sh_pat  = 0; sh_r  = FULL; sh_g  = FULL; sh_b  = FULL;
    endtask

    // Driver: one clock of stimulus plus the model's view of that clock edge
    task automatic step(input bit r, input bit dv, input logic [7:0] b);
        logic [3:0] op, data;
        @(negedge clk);
        rst = r; cmd_dv = dv; cmd_byte = b;
        if (r) begin
            exp_q.push_back({4'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, {(3 * VW){1'b0}}});
            model_reset();
        end else begin
            exp_q.push_back(model_out(m_p, sh_pat, sh_r, sh_g, sh_b, m_fc));
            if (m_p == FRAME - 1) begin
                sh_pat = stg_pat; sh_r = stg_r; sh_g = stg_g; sh_b = stg_b;
                m_fc = (m_fc + 1) % 1024;
                m_p = 0;
            end else begin
                m_p++;
            end
            if (dv) begin
                op = b[7:4];
                data = b[3:0];
                case (op)
                    4'd0: stg_pat = int'(data);
                    4'd1: stg_r = int'(data) >> (4 - VW);
                    4'd2: stg_g = int'(data) >> (4 - VW);
                    4'd3: stg_b = int'(data) >> (4 - VW);
                    default: ;
                endcase
            end
        end
    endtask

    function automatic logic [7:0] rand_cmd();
        int k;
        k = $urandom_range(0, 7);
        if (k < 3) return {4'd0, 4'($urandom_range(0, 7))};
        if (k < 6) return {4'(k - 2), 4'($urandom_range(0, 15))};
        return {4'($urandom_range(4, 15)), 4'($urandom_range(0, 15))};
    endfunction

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 299) == 0) step(1'b0, 1'b1, rand_cmd());
            else step(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i <= FRAME && m_p != target; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compare every output clock against the oldest expectation
    always @(posedge clk) begin
        logic [W-1:0] act, exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {pattern, frame_start, row, col, hsync, vsync, red, grn, blu};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL pixel_out t=%0t got=%h expected=%h", $time, act, exp);
            end
        end
    end

    initial begin
        rst = 1'b1; cmd_dv = 1'b0; cmd_byte = 8'h00;
        model_reset();

        // Reset, with a command during reset that must be dropped
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h04);
        step(1'b1, 1'b0, 8'h00);

        // Bars selected mid-frame, visible from the next frame start
        run(2000, 1'b0);
        step(1'b0, 1'b1, 8'h02);
        run(FRAME, 1'b0);

        // Solid colour with custom levels
        run(1000, 1'b0);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h15);
        step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b1, 8'h3F);
        run(FRAME, 1'b0);

        // Command on the shadow-copy cycle, then an ignored opcode
        run_until(FRAME - 1);
        step(1'b0, 1'b1, 8'h03);
        run(2000, 1'b0);
        step(1'b0, 1'b1, 8'h9A);
        run(2 * FRAME - 2000, 1'b0);

        // Ramp and border frames, then random command traffic
        step(1'b0, 1'b1, 8'h05);
        run(FRAME, 1'b0);
        step(1'b0, 1'b1, 8'h04);
        run(FRAME, 1'b0);
        run(2 * FRAME, 1'b1);

        // One-cycle reset in the middle of row 20
        step(1'b0, 1'b1, 8'h02);
        run_until(20 * TC + 7);
        step(1'b1, 1'b0, 8'h00);
        run(FRAME + 300, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_tp_engine.md
VGA_TP_ENGINE -- requirements
Module: vga_tp_engine

Interface
REQ-001 SHALL have parameter VIDEO_WIDTH, default 3, bits per colour channel, legal range 1..4.
REQ-002 SHALL have parameters TOTAL_COLS 800, TOTAL_ROWS 525, ACTIVE_COLS 640, ACTIVE_ROWS 480; frame geometry in pixels and lines.
REQ-003 SHALL have parameters H_FP 16, H_SYNC 96, V_FP 10, V_SYNC 2; front-porch and sync-pulse widths.
REQ-004 i_Clk  in  1  pixel clock; the block's only clock.
REQ-005 i_Rst  in  1  reset, synchronous and active-high.
REQ-006 i_Cmd_DV  in  1  one-cycle command strobe from the UART receiver.
REQ-007 i_Cmd_Byte  in  8  command: [7:4] opcode, [3:0] data.
REQ-008 o_HSync, o_VSync  out  1 each  active-low sync pulses.
REQ-009 o_Red_Video, o_Grn_Video, o_Blu_Video  out  VIDEO_WIDTH each  pixel colour.
REQ-010 o_Col, o_Row  out  10 each  coordinates of the pixel currently driven on the video outputs.
REQ-011 o_Frame_Start  out  1  one-cycle pulse while pixel (0,0) is driven.
REQ-012 o_Pattern  out  4  pattern index active in the current frame.

Function
REQ-013 Column counter SHALL run 0..TOTAL_COLS-1 and wrap; row counter SHALL increment on column wrap, run 0..TOTAL_ROWS-1 and wrap.
REQ-014 Opcodes: 0 = pattern select, 1 = red level, 2 = green level, 3 = blue level; opcodes 4..15 SHALL be ignored with no state change.
REQ-015 Colour level SHALL be data[3 -: VIDEO_WIDTH], i.e. the MSBs of the data nibble.
REQ-016 Commands SHALL write staging registers on the i_Cmd_DV cycle.
REQ-017 Staging SHALL copy into shadow registers on the cycle the counters equal (TOTAL_COLS-1, TOTAL_ROWS-1); a whole frame SHALL use a single configuration.
REQ-018 A command coinciding with the shadow-copy cycle SHALL update staging only and take effect one frame later.
REQ-019 Patterns: 0 black; 1 solid staged RGB; 2 eight vertical bars, ACTIVE_COLS/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black; 3 checkerboard of 32x32 cells, white when col[5]^row[5], else black; 4 one-pixel white border on active edges, black interior; 5 horizontal ramp, all channels = col[9 -: VIDEO_WIDTH]; 6..15 black.
REQ-020 Outside the active area (col >= ACTIVE_COLS or row >= ACTIVE_ROWS) video SHALL be 0.
REQ-021 o_HSync SHALL be 0 when col is in [ACTIVE_COLS+H_FP, ACTIVE_COLS+H_FP+H_SYNC), else 1; o_VSync likewise from row, V_FP and V_SYNC.
REQ-022 Video, syncs, o_Col, o_Row and o_Frame_Start SHALL be registered with exactly 1-cycle latency from the counters and SHALL be mutually aligned.
REQ-023 Full colour value SHALL be 2^VIDEO_WIDTH-1 on every channel.

Reset
REQ-024 While i_Rst = 1: counters, o_Col, o_Row = 0; o_HSync, o_VSync = 1; video = 0; o_Frame_Start = 0; pattern staging, shadow and o_Pattern = 0; colour staging and shadow = full.
REQ-025 Reset asserted mid-frame SHALL abort the frame; the first cycle after release SHALL count pixel (0,0).
REQ-026 A command presented while i_Rst = 1 SHALL be discarded.

Configuration
REQ-027 With macro VGA_TP_SCROLL_EN defined, the block SHALL keep a 10-bit frame counter, incremented at each shadow copy, wrapping, cleared by reset.
REQ-028 Under VGA_TP_SCROLL_EN, pattern 2 SHALL index its bars with (col + frame_count) mod ACTIVE_COLS, scrolling one pixel per frame.
REQ-029 Without VGA_TP_SCROLL_EN, the frame counter SHALL be absent and pattern 2 SHALL be static.

Structure
REQ-030 Package vga_tp_pkg SHALL hold the opcode constants, the pattern-index constants, the bar colour table and the command field positions.
REQ-031 Sub-module vga_tp_timing SHALL hold the counters and the raw sync decode; vga_tp_engine SHALL hold the command registers, pattern logic and output stage.

Verification
REQ-032 Reset, then free-run 2 frames -> o_Frame_Start period 420000 cycles; HSync low 96 cycles per line starting at col 656; VSync low 2 lines starting at row 490.
REQ-033 Send 0x02 mid-frame -> o_Pattern stays 0 until next o_Frame_Start, then 2; col 0..79 RGB = 7,7,7; col 80..159 RGB = 7,7,0.
REQ-034 Send 0x01, 0x15, 0x20, 0x3F -> next frame every active pixel RGB = 2,0,7; blanking pixels = 0.
REQ-035 i_Cmd_DV with 0x03 on the shadow-copy cycle -> pattern change visible one frame later; 0x9A -> no change.
REQ-036 Assert i_Rst for 1 cycle at row 200 -> outputs take reset values; (0,0) counted the next cycle; o_Frame_Start 1 cycle later.
REQ-037 With VGA_TP_SCROLL_EN and pattern 2 -> bar boundary at col 80 in frame N moves to col 79 in frame N+1.
